// File: rtl/subtractor_3input_pipelined.sv
// Streaming 3-input unsigned subtractor, out = in0 - in1 - in2.
// Two registered stages with valid/ready on both sides; optional clamp-to-zero.
module subtractor_3input_pipelined #(
    parameter int WIDTH    = 16,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             underflow
);

    localparam int DW = WIDTH + 2;

    typedef struct packed {
        logic             v;
        logic [DW-1:0]    d;
        logic [WIDTH-1:0] sub2;
    } s1_t;

    typedef struct packed {
        logic          v;
        logic [DW-1:0] d;
    } s2_t;

    s1_t  s1;
    s2_t  s2;
    logic adv1;
    logic adv2;

    // An empty stage always advances, so bubbles collapse under a stall.
    assign adv2     = !s2.v || out_ready;
    assign adv1     = !s1.v || adv2;
    assign in_ready = adv1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            if (adv1) begin
                s1.v <= in_valid;
                if (in_valid) begin
                    s1.d    <= {2'b00, in0} - {2'b00, in1};
                    s1.sub2 <= in2;
                end
            end
            if (adv2) begin
                s2.v <= s1.v;
                if (s1.v) begin
                    s2.d <= s1.d - {2'b00, s1.sub2};
                end
            end
        end
    end

    // Sign bit of the widened difference flags a negative true result.
    assign out_valid = s2.v;
    assign underflow = s2.d[DW-1];
    assign out       = (SATURATE && underflow) ? '0 : s2.d[WIDTH-1:0];

endmodule

// File: tb/tb_subtractor_3input_pipelined.sv
// Directed bench for subtractor_3input_pipelined (WIDTH=16),
// wrapping and saturating instances driven in parallel.
module tb_subtractor_3input_pipelined;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in0, in1, in2;
    logic        out_ready;
    logic        in_ready, in_ready_s;
    logic        out_valid, out_valid_s;
    logic [15:0] out, out_s;
    logic        underflow, underflow_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    subtractor_3input_pipelined #(.WIDTH(16), .SATURATE(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in0(in0), .in1(in1), .in2(in2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .underflow(underflow)
    );

    subtractor_3input_pipelined #(.WIDTH(16), .SATURATE(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_s),
        .in0(in0), .in1(in1), .in2(in2),
        .out_valid(out_valid_s), .out_ready(out_ready),
        .out(out_s), .underflow(underflow_s)
    );

    typedef struct {
        logic [15:0] a, b, c;
        logic [15:0] exp, exp_sat;
        logic        uf;
    } vec_t;

    vec_t v[8];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int i);
        in0 = v[i].a;
        in1 = v[i].b;
        in2 = v[i].c;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input string tag, input int i);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_out"}, out, v[i].exp);
        check({tag, "_uf"}, underflow, v[i].uf);
        check({tag, "_sat_valid"}, out_valid_s, 1);
        check({tag, "_sat_out"}, out_s, v[i].exp_sat);
        check({tag, "_sat_uf"}, underflow_s, v[i].uf);
    endtask

    initial begin
        int idx, acc, got;

        v[0] = '{16'd10,   16'd3,    16'd2,    16'd5,    16'd5,    1'b0};
        v[1] = '{16'd2,    16'd3,    16'd4,    16'hFFFB, 16'h0000, 1'b1};
        v[2] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b1};
        v[3] = '{16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b0};
        v[4] = '{16'd0,    16'd0,    16'd0,    16'h0000, 16'h0000, 1'b0};
        v[5] = '{16'd100,  16'd50,   16'd50,   16'h0000, 16'h0000, 1'b0};
        v[6] = '{16'd100,  16'd50,   16'd51,   16'hFFFF, 16'h0000, 1'b1};
        v[7] = '{16'h1234, 16'h0034, 16'h0200, 16'h1000, 16'h1000, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in0       = '0;
        in1       = '0;
        in2       = '0;
        out_ready = 1'b1;
        repeat (3) next_cycle();
        rst_n = 1'b1;

        @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_out", out, 0);
        check("reset_uf", underflow, 0);
        check("reset_in_ready", in_ready, 1);
        check("reset_sat_out_valid", out_valid_s, 0);
        next_cycle();

        // Back-to-back stream: each result two cycles after its handshake.
        for (int i = 0; i < 10; i++) begin
            in_valid = (i < 8);
            if (i < 8) drive(i);
            @(negedge clk);
            if (i < 8) check("stream_in_ready", in_ready, 1);
            if (i >= 2) check_vec("stream", i - 2);
            else        check("stream_latency", out_valid, 0);
            next_cycle();
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("stream_empty", out_valid, 0);
        next_cycle();

        // Stall: only two items fit, output held stable.
        out_ready = 1'b0;
        idx = 0;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            drive(idx);
            @(negedge clk);
            if (in_valid && in_ready) begin
                acc++;
                idx++;
            end
            if (c >= 2) begin
                check("stall_in_ready", in_ready, 0);
                check_vec("stall_hold", 0);
            end
            next_cycle();
        end
        check("stall_accepted", acc, 2);

        // Release while still feeding: concurrent in/out handshakes.
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            in_valid = (idx < 4);
            if (idx < 4) drive(idx);
            @(negedge clk);
            if (out_valid) begin
                check_vec("drain", got);
                got++;
            end
            if (in_valid && in_ready) idx++;
            next_cycle();
        end
        in_valid = 1'b0;
        check("drain_count", got, 4);
        check("drain_accepted", idx, 4);

        // Asynchronous reset with both stages full.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(3);
        next_cycle();
        drive(1);
        next_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        check("prereset_full", in_ready, 0);
        check("prereset_out", out, 16'hFFFF);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_out_valid", out_valid, 0);
        check("async_out", out, 0);
        check("async_uf", underflow, 0);
        check("async_sat_out", out_s, 0);
        next_cycle();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("post_reset_out_valid", out_valid, 0);
            check("post_reset_in_ready", in_ready, 1);
            next_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
